// File: rtl/sys_io_pkg.sv
// Shared types and helpers for the console <-> game-pad SPI link.
// Latency: n/a (package).
// Backpressure: n/a (package).
//
// Contents:
//   controller_t / CONTROLLER_BITS  pad snapshot layout {joystick_x, joystick_y, buttons}
//   CRC8_POLY / crc8_24()           CRC-8 (x^8+x^2+x+1, init 0), MSB-first over 24 data bits
//   spi_resp_state_t                responder FSM states
package sys_io_pkg;

    localparam int CONTROLLER_BITS = 24;
    localparam logic [7:0] CRC8_POLY = 8'h07;

    typedef struct packed {
        logic [7:0] joystick_x;
        logic [7:0] joystick_y;
        logic [7:0] buttons;
    } controller_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } spi_resp_state_t;

    // Bit-serial CRC-8, identical on both ends of the link.
    function automatic logic [7:0] crc8_24(input logic [23:0] data);
        logic [7:0] crc;
        crc = 8'h00;
        for (int i = 23; i >= 0; i--) begin
            if (crc[7] ^ data[i]) begin
                crc = {crc[6:0], 1'b0} ^ CRC8_POLY;
            end else begin
                crc = {crc[6:0], 1'b0};
            end
        end
        return crc;
    endfunction

endpackage

// File: rtl/spi_sync.sv
// Synchronizer for one asynchronous SPI pin, plus rise/fall strobes.
// Latency: SYNC_STAGES cycles pin-to-strobe (strobe is combinational off the last two synced samples).
// Backpressure: none; strobes are single-cycle and must be consumed when presented.
//
// Ports:
//   clk_in, rst_in   system clock, async active-low reset
//   pin_in           raw asynchronous pin
//   lvl_out          synchronized level
//   rise_out/fall_out one-cycle edge strobes
module spi_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic pin_in,
    output logic lvl_out,
    output logic rise_out,
    output logic fall_out
);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_stages
        $error("spi_sync: SYNC_STAGES must be 2 or 3");
    end

    // pipe[SYNC_STAGES-1] is the synced sample; the extra top bit is its history
    // used for edge detection.
    logic [SYNC_STAGES:0] pipe;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            pipe <= {(SYNC_STAGES + 1){RESET_VAL}};
        end else begin
            pipe <= {pipe[SYNC_STAGES-1:0], pin_in};
        end
    end

    assign lvl_out  = pipe[SYNC_STAGES-1];
    assign rise_out =  pipe[SYNC_STAGES-1] & ~pipe[SYNC_STAGES];
    assign fall_out = ~pipe[SYNC_STAGES-1] &  pipe[SYNC_STAGES];

endmodule

// File: rtl/spi_pad_responder.sv
// SPI mode-0 responder: shifts a controller snapshot out on MISO, captures a MOSI command word.
// Latency: SYNC_STAGES+1 clk_in cycles from any SPI pin change to its effect; rx_valid/frame_err one cycle after cs_n rise is seen.
// Backpressure: none; the master sets the pace, rx_valid_out/frame_err_out are single-cycle pulses.
//
// Ports: clk_in/rst_in (async active-low); controller_in snapshot at cs_n fall;
//   sclk_in/cs_n_in/mosi_in async SPI inputs; miso_out/miso_oe_out SPI output;
//   rx_data_out/rx_valid_out received word; frame_err_out abort/overrun/CRC error; busy_out in SHIFT.
// Build option: SPI_RESP_CRC8_EN appends a CRC-8 byte to both directions (32-bit frame).
module spi_pad_responder
    import sys_io_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int MIN_SCLK_DIV = 8
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  controller_t                controller_in,
    input  logic                       sclk_in,
    input  logic                       cs_n_in,
    input  logic                       mosi_in,
    output logic                       miso_out,
    output logic                       miso_oe_out,
    output logic [CONTROLLER_BITS-1:0] rx_data_out,
    output logic                       rx_valid_out,
    output logic                       frame_err_out,
    output logic                       busy_out
);

`ifdef SPI_RESP_CRC8_EN
    localparam int FRAME_LEN = CONTROLLER_BITS + 8;
`else
    localparam int FRAME_LEN = CONTROLLER_BITS;
`endif
    localparam int CNT_W = $clog2(FRAME_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN);

    logic sclk_lvl, sclk_rise, sclk_fall;
    logic cs_lvl, cs_rise, cs_fall;
    logic mosi_lvl, mosi_rise, mosi_fall;

    spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
        .clk_in(clk_in), .rst_in(rst_in), .pin_in(sclk_in),
        .lvl_out(sclk_lvl), .rise_out(sclk_rise), .fall_out(sclk_fall)
    );

    // Resets to deselected so a reset release never looks like a frame start.
    spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
        .clk_in(clk_in), .rst_in(rst_in), .pin_in(cs_n_in),
        .lvl_out(cs_lvl), .rise_out(cs_rise), .fall_out(cs_fall)
    );

    spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_mosi_sync (
        .clk_in(clk_in), .rst_in(rst_in), .pin_in(mosi_in),
        .lvl_out(mosi_lvl), .rise_out(mosi_rise), .fall_out(mosi_fall)
    );

    logic unused_sync;
    assign unused_sync = ^{sclk_lvl, cs_lvl, mosi_rise, mosi_fall};

    spi_resp_state_t state, state_nxt;
    logic load, rx_shift, tx_shift, finish;

    logic [FRAME_LEN-1:0] tx_sr, rx_sr, snapshot;
    logic [CNT_W-1:0]     bit_cnt;
    logic                 overrun;
    logic                 frame_good;

`ifdef SPI_RESP_CRC8_EN
    assign snapshot   = {controller_in, crc8_24(controller_in)};
    assign frame_good = (bit_cnt == LAST_CNT) && !overrun &&
                        (crc8_24(rx_sr[FRAME_LEN-1 -: CONTROLLER_BITS]) == rx_sr[7:0]);
`else
    assign snapshot   = controller_in;
    assign frame_good = (bit_cnt == LAST_CNT) && !overrun;
`endif

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // cs_n rise is tested first so an SCLK edge landing in the same synced
    // sample is dropped rather than corrupting the end-of-frame check.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        rx_shift  = 1'b0;
        tx_shift  = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (cs_fall) begin
                    state_nxt = SHIFT;
                    load      = 1'b1;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    state_nxt = DONE;
                    finish    = 1'b1;
                end else if (sclk_rise) begin
                    rx_shift = 1'b1;
                end else if (sclk_fall) begin
                    tx_shift = 1'b1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            tx_sr         <= '0;
            rx_sr         <= '0;
            bit_cnt       <= '0;
            overrun       <= 1'b0;
            miso_out      <= 1'b0;
            miso_oe_out   <= 1'b0;
            rx_data_out   <= '0;
            rx_valid_out  <= 1'b0;
            frame_err_out <= 1'b0;
        end else begin
            rx_valid_out  <= 1'b0;
            frame_err_out <= 1'b0;
            if (load) begin
                tx_sr       <= snapshot;
                bit_cnt     <= '0;
                overrun     <= 1'b0;
                miso_out    <= snapshot[FRAME_LEN-1];
                miso_oe_out <= 1'b1;
            end
            if (rx_shift) begin
                rx_sr <= {rx_sr[FRAME_LEN-2:0], mosi_lvl};
                if (bit_cnt == LAST_CNT) begin
                    overrun <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + CNT_W'(1);
                end
            end
            if (tx_shift) begin
                // Zero fill: once the frame is exhausted MISO reads 0.
                tx_sr    <= {tx_sr[FRAME_LEN-2:0], 1'b0};
                miso_out <= tx_sr[FRAME_LEN-2];
            end
            if (finish) begin
                miso_out    <= 1'b0;
                miso_oe_out <= 1'b0;
                if (frame_good) begin
                    rx_data_out  <= rx_sr[FRAME_LEN-1 -: CONTROLLER_BITS];
                    rx_valid_out <= 1'b1;
                end else begin
                    frame_err_out <= 1'b1;
                end
            end
        end
    end

    assign busy_out = (state == SHIFT);

    // Cycles since the last synced SCLK rise; only feeds the period check below.
    logic [15:0] sclk_gap;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            sclk_gap <= '0;
        end else if (sclk_rise) begin
            sclk_gap <= '0;
        end else if (sclk_gap != 16'hFFFF) begin
            sclk_gap <= sclk_gap + 16'd1;
        end
    end

    a_min_sclk_period: assert property (
        @(posedge clk_in) disable iff (!rst_in)
        (rx_shift && bit_cnt != '0) |-> (sclk_gap >= 16'(MIN_SCLK_DIV - 1))
    );

endmodule

// File: tb/tb_spi_pad_responder.sv
// Directed bench for spi_pad_responder: an SPI master drives frames, a monitor scores rx pulses.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
`timescale 1ns/1ps
module tb_spi_pad_responder;

`ifdef SPI_RESP_CRC8_EN
    localparam int FL = 32;
`else
    localparam int FL = 24;
`endif
    localparam int SYNC = 2;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic [23:0] controller_in = '0;
    logic        sclk_in = 1'b0;
    logic        cs_n_in = 1'b1;
    logic        mosi_in = 1'b0;
    logic        miso_out, miso_oe_out, rx_valid_out, frame_err_out, busy_out;
    logic [23:0] rx_data_out;

    spi_pad_responder #(.SYNC_STAGES(SYNC), .MIN_SCLK_DIV(8)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .controller_in(controller_in),
        .sclk_in(sclk_in), .cs_n_in(cs_n_in), .mosi_in(mosi_in),
        .miso_out(miso_out), .miso_oe_out(miso_oe_out),
        .rx_data_out(rx_data_out), .rx_valid_out(rx_valid_out),
        .frame_err_out(frame_err_out), .busy_out(busy_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic        err;
        logic [23:0] dat;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    task automatic wclk(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic expect_evt(input logic err, input logic [23:0] dat);
        exp_t e;
        e.err = err;
        e.dat = dat;
        exp_q.push_back(e);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_miso"},  miso_out, 0);
        chk({tag, "_oe"},    miso_oe_out, 0);
        chk({tag, "_rxd"},   rx_data_out, 0);
        chk({tag, "_valid"}, rx_valid_out, 0);
        chk({tag, "_err"},   frame_err_out, 0);
        chk({tag, "_busy"},  busy_out, 0);
    endtask

    // CRC-8 as polynomial long division of data*x^8 by 0x107.
    function automatic logic [7:0] tb_crc8(input logic [23:0] d);
        logic [31:0] r;
        r = {d, 8'h00};
        for (int i = 31; i >= 8; i--) begin
            if (r[i]) r[i -: 9] = r[i -: 9] ^ 9'h107;
        end
        return r[7:0];
    endfunction

    function automatic logic [63:0] frame_of(input logic [23:0] d);
`ifdef SPI_RESP_CRC8_EN
        return {32'h0, d, tb_crc8(d)};
`else
        return {40'h0, d};
`endif
    endfunction

    // ev_kind: 0 none, 1 flip controller_in to all ones, 2 reset mid-frame (aborts).
    task automatic spi_frame(input int nbits, input logic [63:0] tx, input int ev_bit,
                             input int ev_kind, output logic [63:0] rd);
        int b;
        rd = '0;
        cs_n_in = 1'b0;
        wclk(10);
        for (int i = nbits - 1; i >= 0; i--) begin
            b = nbits - 1 - i;
            if (b == ev_bit && ev_kind == 1) controller_in = 24'hFFFFFF;
            if (b == ev_bit && ev_kind == 2) begin
                rst_in = 1'b0;
                #1;
                chk_quiet("rst_mid");
                cs_n_in = 1'b1;
                mosi_in = 1'b0;
                wclk(5);
                chk_quiet("rst_hold");
                rst_in = 1'b1;
                wclk(10);
                return;
            end
            mosi_in = tx[i];
            wclk(10);
            sclk_in = 1'b1;
            rd = {rd[62:0], miso_out};
            if (b == 0) begin
                chk("busy_in_frame", busy_out, 1);
                chk("oe_in_frame", miso_oe_out, 1);
            end
            wclk(10);
            sclk_in = 1'b0;
        end
        wclk(10);
        cs_n_in = 1'b1;
        wclk(SYNC + 2);
        chk("oe_drop", miso_oe_out, 0);
        wclk(10);
    endtask

    // Scoreboard monitor.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_in);
            if (rx_valid_out || frame_err_out) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_pulse: valid=%0b err=%0b want none",
                             rx_valid_out, frame_err_out);
                end else begin
                    e = exp_q.pop_front();
                    chk("pulse_kind", {rx_valid_out, frame_err_out}, e.err ? 2'b01 : 2'b10);
                    chk("rx_data", rx_data_out, e.dat);
                end
            end
        end
    end

    initial begin
        logic [63:0] rd;
        logic [23:0] last_good;
        last_good = '0;

        wclk(5);
        chk_quiet("reset");
        rst_in = 1'b1;
        wclk(5);

        // Basic frame
        controller_in = 24'hA53C81;
        expect_evt(1'b0, 24'h123456);
        last_good = 24'h123456;
        spi_frame(FL, frame_of(24'h123456), -1, 0, rd);
        chk("t1_miso", rd, frame_of(24'hA53C81));

        // Early deselect after 10 bits
        controller_in = 24'h0F0F0F;
        expect_evt(1'b1, last_good);
        spi_frame(10, 64'h3FF, -1, 0, rd);
        chk("t2_miso", rd, frame_of(24'h0F0F0F) >> (FL - 10));

        // Overrun: one extra SCLK rise, last MISO bit reads 0
        controller_in = 24'h5AF00F;
        expect_evt(1'b1, last_good);
        spi_frame(FL + 1, (frame_of(24'hCAFE12) << 1) | 64'h1, -1, 0, rd);
        chk("t3_miso", rd, frame_of(24'h5AF00F) << 1);

        // Snapshot stability
        controller_in = 24'h000000;
        expect_evt(1'b0, 24'hABCDEF);
        last_good = 24'hABCDEF;
        spi_frame(FL, frame_of(24'hABCDEF), 5, 1, rd);
        chk("t4_miso_a", rd, frame_of(24'h000000));
        expect_evt(1'b0, 24'h00FF00);
        last_good = 24'h00FF00;
        spi_frame(FL, frame_of(24'h00FF00), -1, 0, rd);
        chk("t4_miso_b", rd, frame_of(24'hFFFFFF));

        // Reset mid-frame, then a clean frame
        controller_in = 24'h13579B;
        spi_frame(FL, frame_of(24'h111111), 12, 2, rd);
        last_good = '0;
        expect_evt(1'b0, 24'h654321);
        last_good = 24'h654321;
        spi_frame(FL, frame_of(24'h654321), -1, 0, rd);
        chk("t5_miso", rd, frame_of(24'h13579B));

`ifdef SPI_RESP_CRC8_EN
        // CRC accept / reject
        controller_in = 24'h000001;
        expect_evt(1'b0, 24'h000000);
        last_good = 24'h000000;
        spi_frame(32, 64'h0, -1, 0, rd);
        chk("t6_miso_a", rd, 64'h00000107);
        expect_evt(1'b1, last_good);
        spi_frame(32, 64'h1, -1, 0, rd);
        chk("t6_miso_b", rd, 64'h00000107);
`endif

        wclk(20);
        chk("pending_events", 64'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
